// File: rtl/am_mod_pkg.sv
// Shared encodings and numeric bounds for the AM modulator.
package am_mod_pkg;
    typedef enum logic [1:0] {
        MODE_FC   = 2'b00,
        MODE_SC   = 2'b01,
        MODE_CAR  = 2'b10,
        MODE_MUTE = 2'b11
    } mode_e;

    function automatic int midscale(input int ow);
        return 1 << (ow - 1);
    endfunction

    function automatic int sat_max(input int cw);
        return (1 << (cw - 1)) - 1;
    endfunction

    function automatic int sat_min(input int cw);
        return -(1 << (cw - 1));
    endfunction
endpackage

// File: rtl/am_modulator_p_if.sv
// Sample/config/result bundle between the TX chain and the AM modulator.
interface am_modulator_p_if #(
    parameter int DW = 16,
    parameter int CW = 16,
    parameter int KW = 8,
    parameter int OW = 6
);
    logic signed [DW-1:0] data_in;
    logic                 data_stb;
    logic signed [CW-1:0] mod_sin;
    logic [1:0]           mode;
    logic [KW-1:0]        depth;
    logic                 sat_clr;
    logic [OW-1:0]        out;
    logic                 out_valid;
    logic                 sat_flag;

    modport master (
        output data_in, data_stb, mod_sin, mode, depth, sat_clr,
        input  out, out_valid, sat_flag
    );
    modport slave (
        input  data_in, data_stb, mod_sin, mode, depth, sat_clr,
        output out, out_valid, sat_flag
    );
endinterface

// File: rtl/am_sat_add.sv
// Combinational signed adder clamping to the W-bit two's complement range.
module am_sat_add
    import am_mod_pkg::*;
#(
    parameter int W = 16
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] sum_o,
    output logic                sat_hit_o
);
    localparam logic signed [W:0] HI = (W+1)'(sat_max(W));
    localparam logic signed [W:0] LO = (W+1)'(sat_min(W));

    logic signed [W:0] raw;

    always_comb begin
        raw       = (W+1)'(a_i) + (W+1)'(b_i);
        sum_o     = raw[W-1:0];
        sat_hit_o = 1'b0;
        if (raw > HI) begin
            sum_o     = HI[W-1:0];
            sat_hit_o = 1'b1;
        end else if (raw < LO) begin
            sum_o     = LO[W-1:0];
            sat_hit_o = 1'b1;
        end
    end
endmodule

// File: rtl/am_modulator_p.sv
// AM modulator: strobed baseband x carrier, depth-scaled, mode-selected,
// saturated and emitted as a top-truncated offset-binary DAC word.
module am_modulator_p
    import am_mod_pkg::*;
#(
    parameter int DW = 16,
    parameter int CW = 16,
    parameter int KW = 8,
    parameter int OW = 6
) (
    input logic             clk,
    input logic             rst_n,
    am_modulator_p_if.slave bus
);
    localparam logic [CW-1:0] MSB = {1'b1, {(CW-1){1'b0}}};

    logic signed [DW-1:0]    data_hold_q;
    mode_e                   mode_r_q, md1_q, md2_q, md3_q;
    logic [KW-1:0]           depth_r_q, dp1_q, dp2_q;
    logic signed [CW-1:0]    car1_q, car2_q, car3_q, r4_q, r4_d;
    logic signed [DW+CW-1:0] p1_q, p1_d;
    logic signed [CW:0]      sc2_q, sc2_d, dt3_q, dt3_d;
    logic signed [CW+KW+1:0] dprod;
    logic signed [CW-1:0]    car_half, add_a, add_b, add_sum;
    logic                    add_hit, hit4_q, hit4_d, sat_flag_q;
    logic [4:0]              vld_pipe_q;
    logic [OW-1:0]           out_q, out_d;

    am_sat_add #(.W(CW)) u_sat (
        .a_i      (add_a),
        .b_i      (add_b),
        .sum_o    (add_sum),
        .sat_hit_o(add_hit)
    );

    always_comb begin
        p1_d     = (DW+CW)'(data_hold_q) * (DW+CW)'(bus.mod_sin);
        sc2_d    = (CW+1)'(p1_q >>> (DW-1));
        dprod    = (CW+KW+2)'(sc2_q) * $signed((CW+KW+2)'(dp2_q));
        dt3_d    = (CW+1)'(dprod >>> KW);
        car_half = car3_q >>> 1;
        add_a    = (md3_q == MODE_FC) ? car_half : '0;
        // |dt3| never exceeds 2^(CW-1) because depth < 1.0, so CW bits hold it
        add_b    = CW'(dt3_q);
        r4_d     = '0;
        hit4_d   = 1'b0;
        case (md3_q)
            MODE_FC, MODE_SC: begin
                r4_d   = add_sum;
                hit4_d = add_hit;
            end
            MODE_CAR: r4_d = car_half;
            default:  r4_d = '0;
        endcase
        out_d = OW'((r4_q ^ MSB) >> (CW-OW));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_hold_q <= '0;
            mode_r_q    <= MODE_MUTE;
            depth_r_q   <= '0;
            car1_q      <= '0;
            car2_q      <= '0;
            car3_q      <= '0;
            p1_q        <= '0;
            sc2_q       <= '0;
            dt3_q       <= '0;
            r4_q        <= '0;
            md1_q       <= MODE_FC;
            md2_q       <= MODE_FC;
            md3_q       <= MODE_FC;
            dp1_q       <= '0;
            dp2_q       <= '0;
            hit4_q      <= 1'b0;
            sat_flag_q  <= 1'b0;
            vld_pipe_q  <= '0;
            out_q       <= OW'(midscale(OW));
        end else begin
            if (bus.data_stb) begin
                data_hold_q <= bus.data_in;
                mode_r_q    <= mode_e'(bus.mode);
                depth_r_q   <= bus.depth;
            end
            car1_q     <= bus.mod_sin;
            p1_q       <= p1_d;
            md1_q      <= mode_r_q;
            dp1_q      <= depth_r_q;
            car2_q     <= car1_q;
            sc2_q      <= sc2_d;
            md2_q      <= md1_q;
            dp2_q      <= dp1_q;
            car3_q     <= car2_q;
            dt3_q      <= dt3_d;
            md3_q      <= md2_q;
            r4_q       <= r4_d;
            hit4_q     <= hit4_d;
            out_q      <= out_d;
            // a fresh hit beats a concurrent clear
            sat_flag_q <= hit4_q | (sat_flag_q & ~bus.sat_clr);
            vld_pipe_q <= {vld_pipe_q[3:0], 1'b1};
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = vld_pipe_q[4];
    assign bus.sat_flag  = sat_flag_q;
endmodule

// File: tb/tb_am_modulator_p.sv
// Bench for am_modulator_p: vector table, hand sequences and random stimulus vs. an arithmetic model.
module tb_am_modulator_p;
    localparam int DW = 16, CW = 16, KW = 8, OW = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    am_modulator_p_if #(.DW(DW), .CW(CW), .KW(KW), .OW(OW)) bus ();
    am_modulator_p #(.DW(DW), .CW(CW), .KW(KW), .OW(OW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        longint ms;
        longint d;
        int     mode;
        longint dep;
    } ent_t;

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  depth;
        logic [15:0] data;
        logic [15:0] ms;
        int          exp_out;
        bit          exp_sat;
    } vec_t;

    ent_t q[$];
    ent_t held;
    int   edges;
    bit   flag_m;
    int   total = 0;
    int   bad = 0;
    vec_t vt[12];

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, exp);
        end
    endtask

    // Sample value straight from the arithmetic definition: product, depth scale, mode, clamp.
    function automatic void ref_out(input ent_t e, output int o, output bit hit);
        longint half, sc, dt, s, hi, lo;
        hi   = (longint'(1) <<< (CW-1)) - 1;
        lo   = -(longint'(1) <<< (CW-1));
        half = e.ms >>> 1;
        sc   = (e.d * e.ms) >>> (DW-1);
        dt   = (sc * e.dep) >>> KW;
        hit  = 1'b0;
        case (e.mode)
            0:       s = half + dt;
            1:       s = dt;
            2:       s = half;
            default: s = 0;
        endcase
        if (e.mode < 2) begin
            if (s > hi) begin s = hi; hit = 1'b1; end
            else if (s < lo) begin s = lo; hit = 1'b1; end
        end
        o = int'((s - lo) >>> (CW-OW));
    endfunction

    task automatic model_reset();
        q.delete();
        repeat (4) q.push_back('{0, 0, 3, 0});
        held   = '{0, 0, 3, 0};
        edges  = 0;
        flag_m = 1'b0;
    endtask

    task automatic tick();
        ent_t e, nh;
        bit   clr, stb;
        int   o;
        bit   hit;
        e    = held;
        e.ms = longint'(bus.mod_sin);
        clr  = bus.sat_clr;
        stb  = bus.data_stb;
        nh   = '{0, longint'(bus.data_in), int'(bus.mode), longint'(bus.depth)};
        @(posedge clk);
        #1;
        q.push_back(e);
        if (stb) held = nh;
        edges++;
        ref_out(q[0], o, hit);
        void'(q.pop_front());
        flag_m = hit | (flag_m & ~clr);
        chk("out", bus.out, o);
        chk("out_valid", bus.out_valid, (edges >= 5) ? 1 : 0);
        chk("sat_flag", bus.sat_flag, flag_m);
    endtask

    task automatic strobe(input logic [1:0] m, input logic [7:0] dep, input logic [15:0] d);
        bus.mode     = m;
        bus.depth    = dep;
        bus.data_in  = d;
        bus.data_stb = 1'b1;
        tick();
        bus.data_stb = 1'b0;
    endtask

    initial begin
        vt[0]  = '{2'b10, 8'd0,   16'h0000, 16'h7FFF, 47, 1'b0};
        vt[1]  = '{2'b10, 8'd0,   16'h0000, 16'h8000, 16, 1'b0};
        vt[2]  = '{2'b00, 8'd0,   16'h7FFF, 16'h7FFF, 47, 1'b0};
        vt[3]  = '{2'b00, 8'd0,   16'h7FFF, 16'h8000, 16, 1'b0};
        vt[4]  = '{2'b00, 8'd255, 16'h7FFF, 16'h7FFF, 63, 1'b1};
        vt[5]  = '{2'b01, 8'd255, 16'h0000, 16'h1234, 32, 1'b0};
        vt[6]  = '{2'b11, 8'd255, 16'h7FFF, 16'h7FFF, 32, 1'b0};
        vt[7]  = '{2'b01, 8'd128, 16'h7FFF, 16'h7FFF, 47, 1'b0};
        vt[8]  = '{2'b00, 8'd255, 16'h8000, 16'h7FFF, 16, 1'b0};
        vt[9]  = '{2'b00, 8'd255, 16'h8000, 16'h8000, 47, 1'b0};
        vt[10] = '{2'b00, 8'd255, 16'h7FFF, 16'h8000, 0,  1'b1};
        vt[11] = '{2'b00, 8'd64,  16'h4000, 16'h7FFF, 51, 1'b0};

        bus.data_in  = '0;
        bus.data_stb = 1'b0;
        bus.mod_sin  = 16'h1111;
        bus.mode     = 2'b11;
        bus.depth    = '0;
        bus.sat_clr  = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", bus.out, 32);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_sat", bus.sat_flag, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("fill_valid", bus.out_valid, (i >= 5) ? 1 : 0);
        end

        for (int i = 0; i < 12; i++) begin
            bus.mod_sin = vt[i].ms;
            strobe(vt[i].mode, vt[i].depth, vt[i].data);
            repeat (6) tick();
            chk($sformatf("vec%0d_out", i), bus.out, vt[i].exp_out);
            bus.sat_clr = 1'b1;
            tick();
            bus.sat_clr = 1'b0;
            tick();
            chk($sformatf("vec%0d_sat", i), bus.sat_flag, vt[i].exp_sat);
        end

        // data_in moves with no strobe: output must not follow
        bus.mod_sin = 16'h7FFF;
        strobe(2'b00, 8'd0, 16'h7FFF);
        repeat (6) tick();
        bus.data_in = 16'h8000;
        repeat (6) tick();
        chk("nostb_out", bus.out, 47);

        // depth change lands exactly 5 edges after its strobe edge
        strobe(2'b00, 8'd255, 16'h7FFF);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("lat_old", bus.out, 47);
        end
        tick();
        chk("lat_new", bus.out, 63);
        tick();
        chk("lat_sat", bus.sat_flag, 1);

        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out", bus.out, 32);
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_sat", bus.sat_flag, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) tick();

        for (int i = 0; i < 600; i++) begin
            bus.data_stb = ($urandom_range(3) == 0);
            bus.data_in  = DW'($urandom);
            bus.mode     = 2'($urandom);
            bus.depth    = KW'($urandom);
            case ($urandom_range(5))
                0:       bus.mod_sin = 16'h7FFF;
                1:       bus.mod_sin = 16'h8000;
                default: bus.mod_sin = CW'($urandom);
            endcase
            if ($urandom_range(7) == 0) bus.data_in = ($urandom_range(1) == 0) ? 16'h7FFF : 16'h8000;
            bus.sat_clr = ($urandom_range(7) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/am_modulator_p.md
Name: am_modulator_p

Overview:
Parametrised successor AM modulator for the SDR TX chain. It multiplies a strobed baseband sample by a carrier sinusoid and scales the product by a programmable modulation depth. Modes are full-carrier AM, suppressed-carrier DSB, carrier-only and mute. Sum paths saturate, and the result is an offset-binary, top-truncated DAC word. It replaces the dual-clock input hold with a single-clock sample strobe and adds a valid flag and a sticky saturation flag.

Parameters:
DW, 16, baseband sample width (signed, >=2)
CW, 16, carrier / internal result width (signed, CW>=OW)
KW, 8, depth word width (unsigned; depth/2^KW = modulation index, 0..(2^KW-1)/2^KW)
OW, 6, output DAC word width (unsigned offset-binary)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
data_in  in  DW  signed baseband sample
data_stb  in  1  one-cycle strobe: capture data_in, mode, depth
mod_sin  in  CW  signed carrier sample, new value every clk
mode  in  2  00 FC (carrier+sidebands), 01 SC (sidebands only), 10 carrier only, 11 mute
depth  in  KW  modulation depth
sat_clr  in  1  clears sat_flag
out  out  OW  offset-binary DAC word
out_valid  out  1  pipeline filled since reset
sat_flag  out  1  sticky: saturation occurred

Behaviour:
- Reset, asynchronous, rst_n=0. Values:
  - out = 2^(OW-1), i.e. mid-scale.
  - out_valid = 0, sat_flag = 0.
  - All pipeline registers = 0.
  - data_hold = 0, depth_r = 0, mode_r = 11 (mute).
- Reset mid-operation: same values apply immediately. out_valid refills after 5 clocks.
- Capture: on clk with data_stb=1, load data_hold<=data_in, mode_r<=mode, depth_r<=depth. Without the strobe these hold their values. Config therefore changes only on sample boundaries.
- Pipeline, one stage per clk:
  - S1: car1<=mod_sin; p1<=data_hold*mod_sin (DW+CW signed).
  - S2: car2<=car1; sc2<=p1>>>(DW-1), truncated to CW+1 bits.
  - S3: car3<=car2; dt3<=(sc2*depth_r)>>>KW, with depth_r zero-extended (unsigned).
  - S4: r4 selected by mode_r:
    - FC: sat(car3>>>1 + dt3)
    - SC: sat(dt3)
    - carrier only: car3>>>1
    - mute: 0
    - sat() clamps to [-2^(CW-1), 2^(CW-1)-1] and raises sat_hit.
  - S5: out<=(r4 XOR 2^(CW-1))[CW-1:CW-OW].
- Latency: mod_sin to out is exactly 5 clk. data_stb to first affected out is 5 clk (1 capture + 4 stages).
- out_valid: 5-bit shift register of 1s after reset; goes high on the 5th clk edge after rst_n deasserts.
- sat_flag:
  - Set on the clk after sat_hit.
  - Cleared by sat_clr.
  - Set and clear in the same cycle: set wins.
- Mode or depth change mid-stream takes effect at S1 of the next strobe. Samples already in flight keep their old mode/depth (mode_r and depth_r are pipelined with the data).
- Arithmetic: all signed with arithmetic shifts, two's complement, no rounding (truncate toward -inf).

Decomposition:
- Package am_mod_pkg holds:
  - mode encodings MODE_FC, MODE_SC, MODE_CAR, MODE_MUTE;
  - function midscale(OW);
  - the saturation bounds as functions of CW.
- One sub-module, am_sat_add: registered-free signed saturating adder, width CW. Inputs a, b; outputs sum and sat_hit.
- All other logic stays inline.

Test Plan:
1. Reset release with defaults: out=32 and out_valid=0 for 4 edges; out_valid=1 from the 5th edge; sat_flag=0.
2. Carrier only, mode=10 strobed, mod_sin=16'h7FFF: out=47 after 5 clk. With mod_sin=16'h8000: out=16.
3. FC, depth=0, data=16'h7FFF: out tracks carrier only (47/16 for the values above). sat_flag stays 0.
4. FC, depth=255, data=16'h7FFF, mod_sin=16'h7FFF: raw sum 16383+32638 saturates to 16'h7FFF; out=63. sat_flag=1 one clk later. sat_clr pulsed together with a new hit leaves sat_flag=1; sat_clr alone clears it.
5. SC, data=0, any carrier: out=32. Mute: out=32 regardless of data and carrier.
6. data_in changing without data_stb leaves out unchanged. Strobe with new depth mid-stream: the first changed out appears exactly 5 clk after the strobe edge. rst_n pulsed low mid-stream forces out=32 asynchronously.
